// File: rtl/ahb_irq_router_if.sv
// rtl/ahb_irq_router_if.sv - AHB-Lite slave bus bundle for the interrupt router
interface ahb_irq_router_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_irq_router.sv
// rtl/ahb_irq_router.sv - interrupt synchroniser, level/edge pending latch and AHB-Lite register window
module ahb_irq_router #(
  parameter int          NUM_SRC      = 16,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] RESET_ENABLE = 16'h0000
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_irq_router_if.slave    ahb,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  output logic [15:0]        IRQ,
  output logic               EVENT
);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s, s_d;
  logic [NUM_SRC-1:0] enable_q, mode_q, pending_q, pending_n, mode_n;
  logic [NUM_SRC-1:0] irq_now, irq_d, wdata;
  logic               dp_valid, dp_write;
  logic [2:0]         dp_addr;
  logic               wr, wr_enable, wr_mode, wr_pend, wr_swset;
  logic [31:0]        rdata;
  logic               unused_ok;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= SRC_IRQ;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end

  // Address phase is captured only while the bus advances.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 3'd0;
    end else if (ahb.HREADY) begin
      dp_valid <= ahb.HSEL & ahb.HTRANS[1];
      dp_write <= ahb.HWRITE;
      dp_addr  <= ahb.HADDR[4:2];
    end
  end

  assign wdata     = ahb.HWDATA[NUM_SRC-1:0];
  assign wr        = dp_valid & dp_write;
  assign wr_enable = wr && (dp_addr == 3'd0);
  assign wr_mode   = wr && (dp_addr == 3'd1);
  assign wr_pend   = wr && (dp_addr == 3'd2);
  assign wr_swset  = wr && (dp_addr == 3'd4);
  assign mode_n    = wr_mode ? wdata : mode_q;

  // Edge set beats a same-cycle write-1-to-clear.
  always_comb begin
    pending_n = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!mode_q[i])
        pending_n[i] = mode_n[i] ? 1'b0 : s[i];
      else
        pending_n[i] = (s[i] & ~s_d[i]) | (wr_swset & wdata[i]) |
                       (pending_q[i] & ~(wr_pend & wdata[i]));
    end
  end

  assign irq_now = pending_q & enable_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      enable_q  <= RESET_ENABLE[NUM_SRC-1:0];
      mode_q    <= '0;
      pending_q <= '0;
      irq_d     <= '0;
      EVENT     <= 1'b0;
    end else begin
      if (wr_enable) enable_q <= wdata;
      mode_q    <= mode_n;
      pending_q <= pending_n;
      irq_d     <= irq_now;
      EVENT     <= |(irq_now & ~irq_d);
    end
  end

  always_comb begin
    IRQ = '0;
    IRQ[NUM_SRC-1:0] = irq_now;
  end

  always_comb begin
    rdata = '0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        3'd0:    rdata[NUM_SRC-1:0] = enable_q;
        3'd1:    rdata[NUM_SRC-1:0] = mode_q;
        3'd2:    rdata[NUM_SRC-1:0] = pending_q;
        3'd3:    rdata[NUM_SRC-1:0] = s;
        default: rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

  assign unused_ok = ^{ahb.HSIZE, ahb.HADDR[31:5], ahb.HADDR[1:0], ahb.HWDATA[31:NUM_SRC]};

endmodule
